dma_controller: RTL and testbench

Bus-master DMA engine sitting directly downstream of the processor. It accepts a multi-word transfer instruction when the processor raises `grant` and moves `count` words between memory and I/O, or between memory regions. It alternates read and write bus cycles, holding the bus via `busybus`. It feeds the processor its live pointers (`next_source`, `next_destination`) and remaining word count (`updated_count`).

---
 rtl/dma_pkg.sv | 30 +++
 rtl/dma_addr_gen.sv | 37 +++
 rtl/dma_controller.sv | 140 ++++++++++++++
 tb/tb_dma_controller.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engine: instruction encodings, bus regions,
// FSM states and the address-to-region decode.
package dma_pkg;

  // {op, type} encodings of the accepted transfer kinds
  localparam logic [3:0] OPTY_MEM_TO_IO  = 4'b0101;
  localparam logic [3:0] OPTY_IO_TO_MEM  = 4'b0001;
  localparam logic [3:0] OPTY_MEM_TO_MEM = 4'b0110;

  localparam int unsigned MEM_TOP  = 191;
  localparam int unsigned IO1_BASE = 192;
  localparam int unsigned IO1_TOP  = 223;
  localparam int unsigned IO2_BASE = 224;
  localparam int unsigned IO2_TOP  = 255;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_e;

  typedef enum logic [1:0] {REG_MEM, REG_IO1, REG_IO2} region_e;

  function automatic region_e decode_region(input logic [7:0] addr,
                                            input int unsigned mem_top = MEM_TOP);
    int unsigned a;
    a = 32'(addr);
    if (a <= mem_top)                      return REG_MEM;
    if (a >= IO1_BASE && a <= IO1_TOP)     return REG_IO1;
    if (a >= IO2_BASE && a <= IO2_TOP)     return REG_IO2;
    return REG_IO2;
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// One DMA pointer: loads a start address, then advances after each write while
// it points into memory (wrapping WRAP_TOP to 0); I/O ports stay fixed.
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int unsigned WRAP_TOP = MEM_TOP
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] load_value,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    // NOTE: default first so every path assigns ptr_d and no latch is inferred.
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_value;
    end else if (advance && decode_region(ptr_q, WRAP_TOP) == REG_MEM) begin
      ptr_d = (ptr_q == ADDR_W'(WRAP_TOP)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking updates so every flop samples pre-edge values.
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/dma_controller.sv
// Bus-master DMA engine alternating READ/WRITE bus cycles for count words.
// Optional feature: define DMA_ABORT_EN to add the abort input.
module dma_controller
  import dma_pkg::*;
#(
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 32,
  parameter int          CNT_W   = 6,
  parameter int unsigned MEM_TOP = 191
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              grant,
  input  logic [25:0]       DMA_instruction,
  input  logic [ADDR_W-1:0] start_source,
  input  logic [ADDR_W-1:0] start_destination,
  inout  wire  [DATA_W-1:0] databus,
  output logic              busybus,
  output logic [ADDR_W-1:0] D_address,
  output logic              D_memwrite,
  output logic              D_IOWrite1,
  output logic              D_IOWrite2,
  output logic [CNT_W-1:0]  updated_count,
  output logic [ADDR_W-1:0] next_source,
  output logic [ADDR_W-1:0] next_destination,
  output logic              done
`ifdef DMA_ABORT_EN
  ,
  input  logic              abort
`endif
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              instr_valid, accept, step;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic              unused_instr_bits;

  assign unused_instr_bits = ^DMA_instruction[21:CNT_W];

  // An X/Z selector matches no item under case equality, so it is ignored.
  always_comb begin
    case (DMA_instruction[25:22])
      OPTY_MEM_TO_IO, OPTY_IO_TO_MEM, OPTY_MEM_TO_MEM: instr_valid = 1'b1;
      default:                                         instr_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hold_d  = hold_q;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant && instr_valid && DMA_instruction[CNT_W-1:0] != '0) begin
          accept  = 1'b1;
          count_d = DMA_instruction[CNT_W-1:0];
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        hold_d  = databus;
        state_d = ST_WRITE;
`ifdef DMA_ABORT_EN
        if (abort) state_d = ST_DONE;
`endif
      end
      ST_WRITE: begin
        step    = 1'b1;
        count_d = count_q - 1'b1;
        state_d = (count_d == '0) ? ST_DONE : ST_READ;
`ifdef DMA_ABORT_EN
        if (abort) state_d = ST_DONE;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

  dma_addr_gen #(.ADDR_W(ADDR_W), .WRAP_TOP(MEM_TOP)) u_src_gen (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .advance    (step),
    .load_value (start_source),
    .ptr        (src_ptr)
  );

  dma_addr_gen #(.ADDR_W(ADDR_W), .WRAP_TOP(MEM_TOP)) u_dst_gen (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .advance    (step),
    .load_value (start_destination),
    .ptr        (dst_ptr)
  );

  always_comb begin
    busybus    = (state_q == ST_READ) || (state_q == ST_WRITE);
    done       = (state_q == ST_DONE);
    D_address  = 'x;
    D_memwrite = 1'b0;
    D_IOWrite1 = 1'b0;
    D_IOWrite2 = 1'b0;
    case (state_q)
      ST_READ:  D_address = src_ptr;
      ST_WRITE: begin
        D_address = dst_ptr;
        case (decode_region(dst_ptr, MEM_TOP))
          REG_MEM: D_memwrite = 1'b1;
          REG_IO1: D_IOWrite1 = 1'b1;
          default: D_IOWrite2 = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  assign databus          = (state_q == ST_WRITE) ? hold_q : 'z;
  assign updated_count    = count_q;
  assign next_source      = src_ptr;
  assign next_destination = dst_ptr;

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench: the bench plays memory/I-O, a transfer-level model
// predicts every read address and write, randomized transfers on top.
module tb_dma_controller;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [2:0]  strobe;
    logic [5:0]  cnt;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        grant = 1'b0;
  logic [25:0] DMA_instruction = '0;
  logic [7:0]  start_source = '0, start_destination = '0;
  wire  [31:0] databus;
  logic        busybus, D_memwrite, D_IOWrite1, D_IOWrite2, done;
  logic [7:0]  D_address, next_source, next_destination;
  logic [5:0]  updated_count;
`ifdef DMA_ABORT_EN
  logic        abort = 1'b0;
`endif

  logic [31:0] bus_mem   [256];
  logic [31:0] model_mem [256];
  wr_t         obs_wr[$];
  logic [7:0]  obs_rd[$];
  int          busy_cycles = 0, done_pulses = 0;
  int          n_compared = 0, n_mismatched = 0;

  wire [2:0] strobes  = {D_IOWrite2, D_IOWrite1, D_memwrite};
  wire       tb_drive = busybus && (strobes == 3'b000);
  assign databus = tb_drive ? bus_mem[D_address] : 'z;

  dma_controller dut (
    .clock             (clock),
    .reset             (reset),
    .grant             (grant),
    .DMA_instruction   (DMA_instruction),
    .start_source      (start_source),
    .start_destination (start_destination),
    .databus           (databus),
    .busybus           (busybus),
    .D_address         (D_address),
    .D_memwrite        (D_memwrite),
    .D_IOWrite1        (D_IOWrite1),
    .D_IOWrite2        (D_IOWrite2),
    .updated_count     (updated_count),
    .next_source       (next_source),
    .next_destination  (next_destination),
    .done              (done)
`ifdef DMA_ABORT_EN
    ,
    .abort             (abort)
`endif
  );

  always #5 clock = ~clock;

  // Bus monitor / memory: observe mid-cycle, away from the rising edge.
  always @(negedge clock) begin
    if (busybus) busy_cycles++;
    if (done) done_pulses++;
    if (busybus && strobes == 3'b000) obs_rd.push_back(D_address);
    if (strobes != 3'b000) begin
      obs_wr.push_back('{addr: D_address, data: databus, strobe: strobes, cnt: updated_count});
      if (D_memwrite) bus_mem[D_address] = databus;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] advance(input logic [7:0] p);
    if (p <= 8'd191) return 8'((32'(p) + 1) % 192);
    return p;
  endfunction

  function automatic logic [2:0] strobe_for(input logic [7:0] a);
    if (a <= 8'd191) return 3'b001;
    if (a <= 8'd223) return 3'b010;
    return 3'b100;
  endfunction

  task automatic launch(input logic [3:0] opty, input logic [7:0] s, input logic [7:0] d,
                        input logic [5:0] cnt);
    @(negedge clock);
    obs_wr.delete();
    obs_rd.delete();
    busy_cycles = 0;
    done_pulses = 0;
    grant = 1'b1;
    DMA_instruction = {opty, 16'($urandom), cnt};
    start_source = s;
    start_destination = d;
    @(negedge clock);
    // grant and inputs are don't-care once the transfer is running
    grant = 1'($urandom);
    DMA_instruction = {4'b1111, 16'($urandom), 6'($urandom)};
    start_source = 8'($urandom);
    start_destination = 8'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit finished);
    finished = 1'b0;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (done_pulses > 0) begin
        finished = 1'b1;
        break;
      end
      @(negedge clock);
    end
    repeat (3) @(negedge clock);
    #1;
    grant = 1'b0;
  endtask

  task automatic run_transfer(input string tag, input logic [3:0] opty, input logic [7:0] s,
                              input logic [7:0] d, input logic [5:0] cnt);
    wr_t         exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  ps, pd;
    logic [31:0] w;
    int          diffs;
    bit          finished;
    ps = s;
    pd = d;
    for (int k = 0; k < int'(cnt); k++) begin
      exp_rd.push_back(ps);
      w = model_mem[ps];
      exp_wr.push_back('{addr: pd, data: w, strobe: strobe_for(pd), cnt: cnt - 6'(k)});
      if (pd <= 8'd191) model_mem[pd] = w;
      ps = advance(ps);
      pd = advance(pd);
    end
    launch(opty, s, d, cnt);
    wait_done(2 * int'(cnt) + 8, finished);
    check({tag, " finished"}, 64'(finished), 64'd1);
    check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(2 * int'(cnt)));
    check({tag, " done_pulses"}, 64'(done_pulses), 64'd1);
    check({tag, " n_reads"}, 64'(obs_rd.size()), 64'(exp_rd.size()));
    check({tag, " n_writes"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
      check($sformatf("%s read[%0d] addr", tag, i), 64'(obs_rd[i]), 64'(exp_rd[i]));
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
      check($sformatf("%s write[%0d] {addr,data,strobe,cnt}", tag, i), 64'(obs_wr[i]), 64'(exp_wr[i]));
    check({tag, " updated_count"}, 64'(updated_count), 64'd0);
    check({tag, " next_source"}, 64'(next_source), 64'(ps));
    check({tag, " next_destination"}, 64'(next_destination), 64'(pd));
    diffs = 0;
    for (int i = 0; i < 256; i++) if (bus_mem[i] !== model_mem[i]) diffs++;
    check({tag, " memory_diffs"}, 64'(diffs), 64'd0);
  endtask

  logic [3:0] bad_opty [5] = '{4'b0000, 4'b1101, 4'b0100, 4'b0111, 4'b1010};
  logic [3:0] good_opty[3] = '{4'b0101, 4'b0001, 4'b0110};

  initial begin
    bit         fin;
    logic [3:0] opty;
    logic [7:0] s, d;
    for (int i = 0; i < 256; i++) bus_mem[i] = $urandom;
    bus_mem[10] = 32'hAAAA_0001;
    bus_mem[11] = 32'hBBBB_0002;
    bus_mem[12] = 32'hCCCC_0003;
    model_mem = bus_mem;

    repeat (3) @(negedge clock);
    #1;
    check("reset busybus", 64'(busybus), 64'd0);
    check("reset strobes", 64'(strobes), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset updated_count", 64'(updated_count), 64'd0);
    check("reset next_source", 64'(next_source), 64'd0);
    check("reset next_destination", 64'(next_destination), 64'd0);
    reset = 1'b0;

    run_transfer("m2m_basic", 4'b0110, 8'd10, 8'd100, 6'd3);
    check("m2m_basic mem[100]", 64'(bus_mem[100]), 64'h AAAA_0001);
    check("m2m_basic mem[102]", 64'(bus_mem[102]), 64'h CCCC_0003);
    run_transfer("m2io1_wrap", 4'b0101, 8'd189, 8'd200, 6'd4);
    run_transfer("io2_to_mem", 4'b0001, 8'd230, 8'd50, 6'd2);

    // Invalid {op,type} codes and a zero count must leave the engine idle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      obs_wr.delete();
      busy_cycles = 0;
      grant = 1'b1;
      if (i < 5) DMA_instruction = {bad_opty[i], 16'($urandom), 6'd5};
      else       DMA_instruction = {4'b0110, 16'($urandom), 6'd0};
      start_source = 8'($urandom);
      start_destination = 8'($urandom);
      repeat (4) @(negedge clock);
      #1;
      check($sformatf("invalid[%0d] busybus", i), 64'(busybus), 64'd0);
      check($sformatf("invalid[%0d] busy_cycles", i), 64'(busy_cycles), 64'd0);
      check($sformatf("invalid[%0d] strobes_seen", i), 64'(obs_wr.size()), 64'd0);
    end
    grant = 1'b0;

    // Reset during the WRITE of word 2 of a 5-word mem->I/O2 transfer.
    launch(4'b0101, 8'd20, 8'd240, 6'd5);
    fin = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (obs_wr.size() == 3) begin
        fin = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("rst_mid reached_write2", 64'(fin), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("rst_mid busybus", 64'(busybus), 64'd0);
    check("rst_mid strobes", 64'(strobes), 64'd0);
    check("rst_mid done", 64'(done), 64'd0);
    check("rst_mid updated_count", 64'(updated_count), 64'd0);
    check("rst_mid next_source", 64'(next_source), 64'd0);
    check("rst_mid next_destination", 64'(next_destination), 64'd0);
    reset = 1'b0;
    grant = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    check("rst_mid writes_total", 64'(obs_wr.size()), 64'd3);
    check("rst_mid done_pulses", 64'(done_pulses), 64'd0);

`ifdef DMA_ABORT_EN
    launch(4'b0101, 8'd5, 8'd210, 6'd5);
    fin = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (obs_wr.size() == 2) begin
        fin = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("abort reached_write1", 64'(fin), 64'd1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    wait_done(10, fin);
    check("abort finished", 64'(fin), 64'd1);
    check("abort writes", 64'(obs_wr.size()), 64'd2);
    check("abort done_pulses", 64'(done_pulses), 64'd1);
    check("abort updated_count", 64'(updated_count), 64'd3);
`endif

    for (int t = 0; t < 10; t++) begin
      opty = good_opty[$urandom_range(2, 0)];
      s = (opty == 4'b0001) ? 8'($urandom_range(255, 192)) : 8'($urandom_range(191, 0));
      d = (opty == 4'b0101) ? 8'($urandom_range(255, 192)) : 8'($urandom_range(191, 0));
      run_transfer($sformatf("rand%0d", t), opty, s, d, 6'($urandom_range(12, 1)));
    end

    run_transfer("count63", 4'b0101, 8'd150, 8'd225, 6'd63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
